// File: rtl/result_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : result_collector_if
//  Brief    : Bundle of control, result and stream signals for the result
//             collector. Signal suffixes are from the collector's viewpoint.
//  Revision : 1.0  initial release
// ============================================================================
interface result_collector_if #(
    parameter int CORES    = 4,
    parameter int RESULT_W = 8,
    parameter int TOTAL_W  = 16,
    parameter int CYCLE_W  = 16
);
    logic                         clear_i;
    logic [CORES*RESULT_W-1:0]    result_i;
    logic [CORES-1:0]             strobe_i;
    logic                         out_ready_i;
    logic                         out_valid_o;
    logic [2:0]                   out_core_o;
    logic [RESULT_W-1:0]          out_data_o;
    logic [CORES-1:0]             done_mask_o;
    logic                         all_done_o;
    logic [TOTAL_W-1:0]           total_o;
    logic [CYCLE_W-1:0]           clk_cycles_o;
    logic                         dup_err_o;

    // Driver side: core array plus downstream consumer
    modport master (
        output clear_i, result_i, strobe_i, out_ready_i,
        input  out_valid_o, out_core_o, out_data_o, done_mask_o,
               all_done_o, total_o, clk_cycles_o, dup_err_o
    );

    // Collector side
    modport slave (
        input  clear_i, result_i, strobe_i, out_ready_i,
        output out_valid_o, out_core_o, out_data_o, done_mask_o,
               all_done_o, total_o, clk_cycles_o, dup_err_o
    );
endinterface
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : result_collector
//  Brief    : Latches one result per core on the falling edge of its strobe,
//             drains them round-robin over a valid/ready stream, accumulates
//             a total and counts cycles until every core is done and drained.
//  Revision : 1.0  initial release
// ============================================================================
module result_collector #(
    parameter int CORES    = 4,
    parameter int RESULT_W = 8,
    parameter int TOTAL_W  = 16,
    parameter int CYCLE_W  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    result_collector_if.slave bus
);
    localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

    logic [RESULT_W-1:0] slot_q [CORES];
    logic [RESULT_W-1:0] slot_d [CORES];
    logic [CORES-1:0]    pending_q, pending_d;
    logic [CORES-1:0]    done_q, done_d;
    logic [CORES-1:0]    prev_q;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic                hold_q, hold_d;
    logic [PTR_W-1:0]    hold_idx_q, hold_idx_d;
    logic [TOTAL_W-1:0]  total_q, total_d;
    logic [CYCLE_W-1:0]  cyc_q, cyc_d;
    logic                dup_q, dup_d;

    logic [CORES-1:0]    fall;
    logic [CORES-1:0]    capture;
    logic [PTR_W-1:0]    grant;
    logic                valid;
    logic                fire;
    logic                all_done;
    logic [RESULT_W-1:0] data;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(CORES - 1)) ? '0 : i + PTR_W'(1);
    endfunction

    assign fall     = prev_q & ~bus.strobe_i;
    assign capture  = fall & ~done_q;
    assign valid    = |pending_q;
    assign fire     = valid & bus.out_ready_i;
    assign all_done = (&done_q) & ~(|pending_q);
    assign data     = valid ? slot_q[grant] : '0;

    // Round-robin grant from rr_q; a presented but unaccepted beat is held so
    // a later capture cannot steal the stream
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        idx   = rr_q;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < CORES; k++) begin
            if (!found && pending_q[idx]) begin
                grant = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        if (hold_q) begin
            grant = hold_idx_q;
        end
    end

    // Next-state: capture, drain, accumulate, count
    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < CORES; i++) begin
            if (capture[i]) begin
                slot_d[i] = bus.result_i[RESULT_W*i +: RESULT_W];
            end
        end
        pending_d = pending_q;
        if (fire) begin
            pending_d[grant] = 1'b0;
        end
        pending_d  = pending_d | capture;
        done_d     = done_q | capture;
        total_d    = fire ? total_q + TOTAL_W'(data) : total_q;
        rr_d       = fire ? next_idx(grant) : rr_q;
        hold_d     = valid & ~bus.out_ready_i;
        hold_idx_d = grant;
        cyc_d      = (!all_done && cyc_q != '1) ? cyc_q + CYCLE_W'(1) : cyc_q;
        dup_d      = dup_q | (|(fall & done_q));
    end

    // State registers; async reset and sync clear both return to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CORES; i++) slot_q[i] <= '0;
            pending_q  <= '0;
            done_q     <= '0;
            prev_q     <= '0;
            rr_q       <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            total_q    <= '0;
            cyc_q      <= '0;
            dup_q      <= 1'b0;
        end else if (bus.clear_i) begin
            for (int i = 0; i < CORES; i++) slot_q[i] <= '0;
            pending_q  <= '0;
            done_q     <= '0;
            prev_q     <= '0;
            rr_q       <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            total_q    <= '0;
            cyc_q      <= '0;
            dup_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            prev_q     <= bus.strobe_i;
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            total_q    <= total_d;
            cyc_q      <= cyc_d;
            dup_q      <= dup_d;
        end
    end

    assign bus.out_valid_o  = valid;
    assign bus.out_core_o   = valid ? 3'(grant) : 3'd0;
    assign bus.out_data_o   = data;
    assign bus.done_mask_o  = done_q;
    assign bus.all_done_o   = all_done;
    assign bus.total_o      = total_q;
    assign bus.clk_cycles_o = cyc_q;
    assign bus.dup_err_o    = dup_q;
endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_collector
//  Brief    : Directed self-checking bench for result_collector.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    result_collector_if                bus  ();
    result_collector_if #(.CYCLE_W(4)) bus2 ();

    result_collector u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    result_collector #(.CYCLE_W(4)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.clear_i      = 1'b0;
        bus.result_i     = '0;
        bus.strobe_i     = '0;
        bus.out_ready_i  = 1'b1;
        bus2.clear_i     = 1'b0;
        bus2.result_i    = '0;
        bus2.strobe_i    = '0;
        bus2.out_ready_i = 1'b1;

        // Reset state
        tick();
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_total", bus.total_o, 0);
        chk("rst_cycles", bus.clk_cycles_o, 0);
        chk("rst_done", bus.done_mask_o, 0);
        chk("rst_dup", bus.dup_err_o, 0);

        // Staggered finish, plus saturation of the narrow counter alongside
        bus.result_i = {8'd14, 8'd13, 8'd14, 8'd13};
        bus.strobe_i = 4'hF;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            for (int i = 0; i < 4; i++) bus.strobe_i[i] = (e < 10 * (i + 1));
            tick();
            if (e == 10 || e == 20 || e == 30 || e == 40) begin
                chk("stag_valid", bus.out_valid_o, 1);
                chk("stag_core", bus.out_core_o, e / 10 - 1);
                chk("stag_data", bus.out_data_o, ((e / 10) % 2 == 1) ? 13 : 14);
            end
            if (e == 14) chk("sat_cnt14", bus2.clk_cycles_o, 14);
            if (e == 20) begin
                chk("sat_cnt", bus2.clk_cycles_o, 15);
                chk("sat_alldone", bus2.all_done_o, 0);
            end
            if (e == 30) chk("sat_hold", bus2.clk_cycles_o, 15);
            if (e == 21) chk("stag_total21", bus.total_o, 27);
            if (e == 40) chk("stag_notdone", bus.all_done_o, 0);
            if (e == 41) begin
                chk("stag_alldone", bus.all_done_o, 1);
                chk("stag_total", bus.total_o, 16'h36);
                chk("stag_cycles", bus.clk_cycles_o, 41);
                chk("stag_idle", bus.out_valid_o, 0);
            end
            if (e == 45) chk("stag_frozen", bus.clk_cycles_o, 41);
        end

        // Simultaneous finish
        bus.result_i = {8'd8, 8'd7, 8'd6, 8'd5};
        bus.strobe_i = 4'hF;
        do_reset();
        tick();
        tick();
        bus.strobe_i = 4'h0;
        tick();
        chk("sim_mask", bus.done_mask_o, 4'hF);
        chk("sim_core0", bus.out_core_o, 0);
        chk("sim_data0", bus.out_data_o, 5);
        tick();
        chk("sim_core1", bus.out_core_o, 1);
        chk("sim_data1", bus.out_data_o, 6);
        tick();
        chk("sim_core2", bus.out_core_o, 2);
        tick();
        chk("sim_core3", bus.out_core_o, 3);
        chk("sim_data3", bus.out_data_o, 8);
        chk("sim_notdone", bus.all_done_o, 0);
        tick();
        chk("sim_alldone", bus.all_done_o, 1);
        chk("sim_total", bus.total_o, 26);
        chk("sim_cycles", bus.clk_cycles_o, 7);

        // Backpressure with rr_ptr at 2
        bus.result_i = {8'd40, 8'd30, 8'd2, 8'd1};
        bus.strobe_i = 4'hF;
        do_reset();
        tick();
        tick();
        bus.strobe_i = 4'b1100;
        tick();
        tick();
        tick();
        chk("bp_pre_total", bus.total_o, 3);
        chk("bp_pre_idle", bus.out_valid_o, 0);
        bus.out_ready_i = 1'b0;
        bus.strobe_i    = 4'h0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_core", bus.out_core_o, 2);
            chk("bp_data", bus.out_data_o, 30);
            chk("bp_total", bus.total_o, 3);
        end
        bus.out_ready_i = 1'b1;
        tick();
        chk("bp_core3", bus.out_core_o, 3);
        chk("bp_data3", bus.out_data_o, 40);
        chk("bp_total2", bus.total_o, 33);
        tick();
        chk("bp_total3", bus.total_o, 73);
        chk("bp_alldone", bus.all_done_o, 1);

        // Duplicate strobe
        bus.result_i    = {8'd0, 8'd0, 8'd7, 8'd0};
        bus.strobe_i    = 4'hF;
        bus.out_ready_i = 1'b0;
        do_reset();
        tick();
        tick();
        bus.strobe_i = 4'b1101;
        tick();
        chk("dup_core", bus.out_core_o, 1);
        chk("dup_data", bus.out_data_o, 7);
        chk("dup_none", bus.dup_err_o, 0);
        bus.strobe_i = 4'hF;
        bus.result_i = {8'd0, 8'd0, 8'd99, 8'd0};
        tick();
        bus.strobe_i = 4'b1101;
        tick();
        chk("dup_err", bus.dup_err_o, 1);
        chk("dup_keep", bus.out_data_o, 7);
        bus.out_ready_i = 1'b1;
        tick();
        chk("dup_total", bus.total_o, 7);
        chk("dup_drained", bus.out_valid_o, 0);
        chk("dup_sticky", bus.dup_err_o, 1);

        // Synchronous clear, then clear coinciding with a falling edge
        bus.strobe_i = 4'hF;
        bus.clear_i  = 1'b1;
        tick();
        chk("clr_total", bus.total_o, 0);
        chk("clr_dup", bus.dup_err_o, 0);
        bus.clear_i = 1'b0;
        tick();
        bus.strobe_i = 4'b1110;
        bus.clear_i  = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        tick();
        chk("clr_edge_lost", bus.done_mask_o, 0);
        chk("clr_idle", bus.out_valid_o, 0);

        // Reset asserted mid-drain, then a fresh run
        bus.result_i = {8'd44, 8'd33, 8'd22, 8'd11};
        bus.strobe_i = 4'hF;
        do_reset();
        tick();
        tick();
        bus.strobe_i = 4'h0;
        tick();
        tick();
        tick();
        chk("mid_total", bus.total_o, 33);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_valid", bus.out_valid_o, 0);
        chk("mid_data", bus.out_data_o, 0);
        chk("mid_core", bus.out_core_o, 0);
        chk("mid_total0", bus.total_o, 0);
        chk("mid_mask", bus.done_mask_o, 0);
        chk("mid_cycles", bus.clk_cycles_o, 0);
        bus.result_i = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.strobe_i = 4'hF;
        tick();
        rst = 1'b0;
        tick();
        tick();
        bus.strobe_i = 4'h0;
        for (int c = 0; c < 5; c++) tick();
        chk("rerun_total", bus.total_o, 10);
        chk("rerun_alldone", bus.all_done_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
